// File: rtl/jzjpcc_encode_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Formats, major opcodes, FIFO entry layout and an immediate-fit helper.
package jzjpcc_encode_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_BAD6 = 3'd6,
        FMT_BAD7 = 3'd7
    } format_t;

    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] OP     = 5'b01100;

    typedef struct packed {
        logic [31:0] word;
        logic        error;
    } enc_entry_t;

    // True when v[31:lsb] are all equal, i.e. v sign-fits in lsb+1 bits
    function automatic logic fits_signed(
        input logic [31:0] v,
        input int unsigned lsb
    );
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lsb;
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/jzjpcc_instruction_encoder_if.sv
// Request/response bundle between the injector and the encoder.
// master drives requests and consumes words; slave is the encoder.
interface jzjpcc_instruction_encoder_if;
    import jzjpcc_encode_pkg::*;

    logic        in_valid;
    logic        in_ready;
    format_t     in_format;
    logic [4:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic        out_error;

    modport master (
        output in_valid, in_format, in_opcode,
        output in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_immediate,
        output out_ready,
        input  in_ready, out_valid,
        input  out_instruction, out_error
    );

    modport slave (
        input  in_valid, in_format, in_opcode,
        input  in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_immediate,
        input  out_ready,
        output in_ready, out_valid,
        output out_instruction, out_error
    );

endinterface

// File: rtl/jzjpcc_encoder_fifo2.sv
// Two-entry FIFO with a registered ready, so the upstream side
// never sees a combinational path from the downstream ready.
module jzjpcc_encoder_fifo2 #(
    parameter type T = logic [32:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    T           mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       ready_q;
    logic       push;
    logic       pop;

    assign push    = valid_i & ready_q;
    assign pop     = valid_o & ready_i;
    assign valid_o = (count_q != 2'd0);
    assign ready_o = ready_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/jzjpcc_instruction_encoder.sv
// Scatters a full immediate into RV32I I/S/B/U/J layouts and flags
// immediates that do not fit; words are buffered in a 2-entry FIFO.
module jzjpcc_instruction_encoder
    import jzjpcc_encode_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    jzjpcc_instruction_encoder_if.slave bus,
    output logic [COUNT_WIDTH-1:0] count_encoded,
    output logic [COUNT_WIDTH-1:0] count_errors
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

    logic [6:0]  opc;
    logic [31:0] imm;
    logic [31:0] word;
    logic        rng_err;
    logic        bad_fmt;
    enc_entry_t  enc;
    enc_entry_t  head;
    logic        fifo_ready;
    logic        fifo_valid;
    logic        accept;

    logic [COUNT_WIDTH-1:0] enc_cnt_q;
    logic [COUNT_WIDTH-1:0] err_cnt_q;

    always_comb begin
        opc     = {bus.in_opcode, 2'b11};
        imm     = bus.in_immediate;
        word    = 32'h0;
        rng_err = 1'b0;
        bad_fmt = 1'b0;
        case (bus.in_format)
            FMT_R: begin
                word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_rd, opc};
            end
            FMT_I: begin
                word    = {imm[11:0], bus.in_rs1,
                           bus.in_funct3, bus.in_rd, opc};
                rng_err = ~fits_signed(imm, 11);
            end
            FMT_S: begin
                word    = {imm[11:5], bus.in_rs2, bus.in_rs1,
                           bus.in_funct3, imm[4:0], opc};
                rng_err = ~fits_signed(imm, 11);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], bus.in_rs2,
                           bus.in_rs1, bus.in_funct3,
                           imm[4:1], imm[11], opc};
                rng_err = ~fits_signed(imm, 12) | imm[0];
            end
            FMT_U: begin
                word    = {imm[31:12], bus.in_rd, opc};
                rng_err = |imm[11:0];
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11],
                           imm[19:12], bus.in_rd, opc};
                rng_err = ~fits_signed(imm, 20) | imm[0];
            end
            default: begin
                word    = 32'h0;
                bad_fmt = 1'b1;
            end
        endcase
        enc.word  = word;
        enc.error = bad_fmt | (CHECK_RANGE & rng_err);
    end

    jzjpcc_encoder_fifo2 #(
        .T (enc_entry_t)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .valid_i (bus.in_valid),
        .ready_o (fifo_ready),
        .data_i  (enc),
        .valid_o (fifo_valid),
        .ready_i (bus.out_ready),
        .data_o  (head)
    );

    assign bus.in_ready        = fifo_ready;
    assign bus.out_valid       = fifo_valid;
    assign bus.out_instruction = head.word;
    assign bus.out_error       = head.error;

    assign accept = bus.in_valid & fifo_ready;

    // Counters stick at all-ones instead of wrapping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (accept) begin
            if (!(&enc_cnt_q)) begin
                enc_cnt_q <= enc_cnt_q + CNT_ONE;
            end
            if (enc.error && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + CNT_ONE;
            end
        end
    end

    assign count_encoded = enc_cnt_q;
    assign count_errors  = err_cnt_q;

endmodule

// File: tb/tb_jzjpcc_instruction_encoder.sv
// Table-driven bench with an expected-word scoreboard for the encoder.
// A second COUNT_WIDTH=2 instance shadows the inputs for saturation.
module tb_jzjpcc_instruction_encoder;
    import jzjpcc_encode_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    jzjpcc_instruction_encoder_if bi ();
    jzjpcc_instruction_encoder_if bs ();

    logic [15:0] cnt_enc, cnt_err;
    logic [1:0]  sat_enc, sat_err;

    jzjpcc_instruction_encoder #(
        .COUNT_WIDTH (16),
        .CHECK_RANGE (1'b1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bi),
        .count_encoded (cnt_enc),
        .count_errors  (cnt_err)
    );

    jzjpcc_instruction_encoder #(
        .COUNT_WIDTH (2),
        .CHECK_RANGE (1'b1)
    ) u_sat (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bs),
        .count_encoded (sat_enc),
        .count_errors  (sat_err)
    );

    assign bs.in_valid     = bi.in_valid;
    assign bs.in_format    = bi.in_format;
    assign bs.in_opcode    = bi.in_opcode;
    assign bs.in_rd        = bi.in_rd;
    assign bs.in_rs1       = bi.in_rs1;
    assign bs.in_rs2       = bi.in_rs2;
    assign bs.in_funct3    = bi.in_funct3;
    assign bs.in_funct7    = bi.in_funct7;
    assign bs.in_immediate = bi.in_immediate;
    assign bs.out_ready    = 1'b1;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t       vecs [14];
    enc_entry_t sb [$];
    enc_entry_t pend;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_enc = 0;
    int         exp_err = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bi.in_valid     = 1'b1;
        bi.in_format    = format_t'(v.fmt);
        bi.in_opcode    = v.opc;
        bi.in_rd        = v.rd;
        bi.in_rs1       = v.rs1;
        bi.in_rs2       = v.rs2;
        bi.in_funct3    = v.f3;
        bi.in_funct7    = v.f7;
        bi.in_immediate = v.imm;
        pend.word       = v.word;
        pend.error      = v.err;
    endtask

    // Evaluate handshakes just before the edge, then advance one cycle
    task automatic cycle(output bit acc);
        enc_entry_t e;
        #1;
        acc = bi.in_valid && bi.in_ready;
        if (bi.out_valid && bi.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h expected none",
                         bi.out_instruction);
            end else begin
                e = sb.pop_front();
                chk("out_instruction", bi.out_instruction, e.word);
                chk("out_error", {31'h0, bi.out_error},
                    {31'h0, e.error});
            end
        end
        if (acc) begin
            sb.push_back(pend);
            exp_enc++;
            if (pend.error) exp_err++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send(input vec_t v);
        bit acc;
        bit done;
        done = 1'b0;
        drive(v);
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(acc);
            if (acc) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        bi.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        bi.in_valid  = 1'b0;
        bi.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(acc);
        chk("drain_left", sb.size(), 0);
        cycle(acc);
    endtask

    initial begin
        bit acc;
        int nacc;
        vecs[0]  = '{3'd1, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
        vecs[1]  = '{3'd2, 5'b01000, 5'd31, 5'd1, 5'd2, 3'd2, 7'd0,
                     32'h0000_0008, 32'h0020_A423, 1'b0};
        vecs[2]  = '{3'd3, 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        vecs[3]  = '{3'd4, 5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h1234_5000, 32'h1234_52B7, 1'b0};
        vecs[4]  = '{3'd5, 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h0000_0800, 32'h0010_00EF, 1'b0};
        vecs[5]  = '{3'd3, 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h0000_0003, 32'h0000_0163, 1'b1};
        vecs[6]  = '{3'd1, 5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h0000_0800, 32'h8000_0013, 1'b1};
        vecs[7]  = '{3'd7, 5'b00100, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
                     32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[8]  = '{3'd0, 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,
                     32'hDEAD_BEEF, 32'h4020_81B3, 1'b0};
        vecs[9]  = '{3'd4, 5'b01101, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h1234_5001, 32'h1234_5037, 1'b1};
        vecs[10] = '{3'd5, 5'b11011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h0000_0001, 32'h0000_006F, 1'b1};
        vecs[11] = '{3'd2, 5'b01000, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0,
                     32'hFFFF_FFFF, 32'hFE00_2FA3, 1'b0};
        vecs[12] = '{3'd1, 5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'hFFFF_F7FF, 32'h7FF0_0013, 1'b1};
        vecs[13] = '{3'd6, 5'b00000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h0000_0000, 32'h0000_0000, 1'b1};

        bi.in_valid     = 1'b0;
        bi.in_format    = FMT_R;
        bi.in_opcode    = 5'd0;
        bi.in_rd        = 5'd0;
        bi.in_rs1       = 5'd0;
        bi.in_rs2       = 5'd0;
        bi.in_funct3    = 3'd0;
        bi.in_funct7    = 7'd0;
        bi.in_immediate = 32'd0;
        bi.out_ready    = 1'b1;
        pend            = '0;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        chk("rst_out_valid", {31'h0, bi.out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, bi.in_ready}, 32'd1);
        chk("rst_out_instr", bi.out_instruction, 32'd0);
        chk("rst_out_error", {31'h0, bi.out_error}, 32'd0);
        chk("rst_cnt_enc", {16'h0, cnt_enc}, 32'd0);
        chk("rst_cnt_err", {16'h0, cnt_err}, 32'd0);
        @(negedge clock);

        // Single ADDI: valid must rise right after the accepting edge
        drive(vecs[0]);
        cycle(acc);
        chk("lat_accept", {31'h0, acc}, 32'd1);
        chk("lat_out_valid", {31'h0, bi.out_valid}, 32'd1);
        bi.in_valid = 1'b0;
        drain();

        for (int i = 0; i < 8; i++) send(vecs[i]);
        drain();
        chk("mid_cnt_err", {16'h0, cnt_err}, exp_err);
        chk("mid_cnt_enc", {16'h0, cnt_enc}, exp_enc);
        for (int i = 8; i < 14; i++) send(vecs[i]);
        drain();
        chk("tbl_cnt_err", {16'h0, cnt_err}, exp_err);
        chk("tbl_cnt_enc", {16'h0, cnt_enc}, exp_enc);

        // Backpressure: third request waits for the first pop
        bi.out_ready = 1'b0;
        nacc = 0;
        drive(vecs[1]);
        cycle(acc);
        nacc += int'(acc);
        drive(vecs[3]);
        cycle(acc);
        nacc += int'(acc);
        drive(vecs[8]);
        cycle(acc);
        nacc += int'(acc);
        cycle(acc);
        nacc += int'(acc);
        chk("bp_accepted", nacc, 2);
        chk("bp_in_ready_full", {31'h0, bi.in_ready}, 32'd0);
        bi.out_ready = 1'b1;
        cycle(acc);
        chk("bp_no_accept_on_pop", {31'h0, acc}, 32'd0);
        chk("bp_in_ready_after", {31'h0, bi.in_ready}, 32'd1);
        cycle(acc);
        chk("bp_third_accept", {31'h0, acc}, 32'd1);
        drain();
        chk("bp_cnt_enc", {16'h0, cnt_enc}, exp_enc);

        // Asynchronous reset with two entries queued
        bi.out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[5]);
        chk("pre_rst_full", {31'h0, bi.in_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'h0, bi.out_valid}, 32'd0);
        chk("arst_in_ready", {31'h0, bi.in_ready}, 32'd1);
        chk("arst_out_instr", bi.out_instruction, 32'd0);
        chk("arst_cnt_enc", {16'h0, cnt_enc}, 32'd0);
        chk("arst_cnt_err", {16'h0, cnt_err}, 32'd0);
        sb.delete();
        exp_enc = 0;
        exp_err = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Saturation: 5 accepts, the 2-bit instance must stick at 3
        bi.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(vecs[0]);
        drain();
        chk("sat_main_enc", {16'h0, cnt_enc}, exp_enc);
        chk("sat_small_enc", {30'h0, sat_enc}, 32'd3);
        chk("sat_small_err", {30'h0, sat_err}, 32'd0);
        send(vecs[5]);
        drain();
        chk("sat_small_enc2", {30'h0, sat_enc}, 32'd3);
        chk("sat_small_err2", {30'h0, sat_err}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jzjpcc_instruction_encoder.md
Name: jzjpcc_instruction_encoder

Overview:
Inverse of decode-stage immediate extraction. Takes instruction fields plus a full 32-bit immediate and scatters the immediate into RV32I I/S/B/U/J bit positions, producing a 32-bit instruction word. Checks that each immediate fits its format. Serves the self-test/debug instruction injector that feeds words into fetch. Buffered valid/ready on both sides.

Parameters:
COUNT_WIDTH, 16, width of the saturating accepted-instruction and error counters.
CHECK_RANGE, 1, 1 = immediate range/alignment checking enabled; 0 = out_error forced 0 except for an invalid format.

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  encoder can accept; registered, no combinational path from out_ready
in_format  input  3  format_t: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are invalid
in_opcode  input  5  instruction bits [6:2]; bits [1:0] always emitted as 2'b11
in_rd / in_rs1 / in_rs2  input  5 each  register fields
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R format only)
in_immediate  input  32  full signed/unsigned immediate value
out_valid  output  1  encoded word available
out_ready  input  1  consumer accepts
out_instruction  output  32  encoded word
out_error  output  1  immediate out of range/misaligned, or invalid format (qualified by out_valid)
count_encoded  output  COUNT_WIDTH  saturating count of accepted requests
count_errors  output  COUNT_WIDTH  saturating count of accepted requests flagged with an error

Behaviour:
- Reset (async assert, sync release): buffer empty; out_valid=0, in_ready=1, out_instruction=0, out_error=0, both counters 0.
- Input handshake: accept when in_valid && in_ready. Encoding is combinational on the inputs and written into a 2-entry FIFO on the same edge.
- Latency: a request accepted at edge N with the FIFO empty gives out_valid=1 after edge N.
- Output: out_instruction/out_error come from the FIFO head. Pop on out_valid && out_ready. Order is preserved.
- in_ready is registered: 1 iff occupancy after this edge is < 2. Push and pop in the same cycle leave occupancy unchanged. A push while full is impossible.
- Encoding (opc = {in_opcode, 2'b11}):
  - R: {funct7, rs2, rs1, funct3, rd, opc}.
  - I: {imm[11:0], rs1, funct3, rd, opc}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opc}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc}.
  - U: {imm[31:12], rd, opc}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}.
  - Unused fields are ignored.
- Range checks (CHECK_RANGE=1). The word is still emitted with truncated fields.
  - I/S: imm[31:11] not all-equal → error.
  - B: imm[31:12] not all-equal, or imm[0]=1 → error.
  - J: imm[31:20] not all-equal, or imm[0]=1 → error.
  - U: imm[11:0] ≠ 0 → error.
  - R: never errors.
- Invalid format 6/7: word = 32'h00000000, error = 1, regardless of CHECK_RANGE.
- Counters:
  - count_encoded increments on every accept.
  - count_errors increments on accepts flagged with an error.
  - Both saturate at all-ones, never wrap.
- Reset mid-operation: FIFO contents discarded immediately; outputs take reset values asynchronously.

Decomposition:
- Shared package jzjpcc_encode_pkg holds:
  - format_t enum;
  - opcode constants LOAD=5'b00000, OP_IMM=5'b00100, AUIPC=5'b00101, STORE=5'b01000, LUI=5'b01101, BRANCH=5'b11000, JAL=5'b11011, JALR=5'b11001, OP=5'b01100;
  - a packed struct {logic [31:0] word; logic error;} for FIFO entries.
- One sub-module: jzjpcc_encoder_fifo2, a 2-entry registered-ready FIFO parameterized on entry type.
- Encoding and range checks stay combinational in the top.

Test Plan:
- ADDI x1,x0,-1: format I, opcode 00100, rd=1, rs1=0, f3=0, imm=FFFFFFFF → out_instruction=FFF00093, out_error=0; out_valid one cycle after accept.
- SW x2,8(x1): format S, opcode 01000, f3=010, rs1=1, rs2=2, imm=8 → 0020A423. Then BEQ x0,x0,-4: format B, opcode 11000, imm=FFFFFFFC → FE000EE3. Both error=0, in order.
- LUI x5: format U, opcode 01101, rd=5, imm=12345000 → 123452B7. JAL x1,+2048: format J, opcode 11011, imm=00000800 → 001000EF.
- Error cases, each error=1, count_errors=3 afterwards:
  - format B, imm=3;
  - format I, imm=00000800;
  - format 7 → word 00000000.
- Backpressure: out_ready=0, in_valid=1 with three distinct requests → exactly 2 accepted, in_ready=0. Raise out_ready → words drain in order, third accepted on the cycle after the first pop; count_encoded=3.
- Assert reset_n low with 2 entries queued → out_valid=0, in_ready=1, counters 0 without a clock edge. Counter saturation is checked with COUNT_WIDTH=2: 5 accepts → count_encoded=3.
